spi_reg_bank: RTL

- Parametrised SPI-side register bank; successor to the fixed 16-channel SPI register buffer.
- Sits between the SPI slave word engine (cmd_flag/data_flag/dcmd/din/dout) and FPGA user logic.
- Adds: arbitrary channel count, per-channel write-protect, reset values, auto-increment burst addressing, per-channel write/read strobes, error reporting.
- Uses flattened channel buses.

---
 rtl/spi_reg_bank.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI-side register bank: channel reads/writes, write-protect, auto-increment bursts, strobes, errors.
// Define SPI_REG_SHADOW_EN to stage writes in a shadow array copied to read_reg on commit.
module spi_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNEL_NUMBER = 16,
  parameter logic [CHANNEL_NUMBER-1:0] WRITABLE_MASK = '1,
  parameter logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int ADDR_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_flag,
  input  logic [ADDR_WIDTH:0]                  dcmd,
  input  logic                                 data_flag,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic [DATA_WIDTH-1:0]                dout,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] write_reg,
  output logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] read_reg,
  output logic [CHANNEL_NUMBER-1:0]            wr_stb,
  output logic [CHANNEL_NUMBER-1:0]            rd_stb,
  output logic                                 err
`ifdef SPI_REG_SHADOW_EN
  ,
  input  logic                                 commit
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(CHANNEL_NUMBER - 1);

  logic [0:0]                          r_state;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic                                r_inc;
  logic [DATA_WIDTH-1:0]               r_dout;
  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] r_readReg;
  logic [CHANNEL_NUMBER-1:0]           r_wrStb;
  logic [CHANNEL_NUMBER-1:0]           r_rdStb;
  logic                                r_err;

  logic                                w_armed;
  logic                                w_dataOk;
  logic                                w_err;
  logic [CHANNEL_NUMBER-1:0]           w_sel;
  logic [CHANNEL_NUMBER-1:0]           w_rdHot;
  logic [CHANNEL_NUMBER-1:0]           w_wrHot;
  logic [DATA_WIDTH-1:0]               w_doutNext;

  assign w_armed  = (r_state == ST_ARMED);
  assign w_dataOk = data_flag && !cmd_flag && w_armed;

  // One-hot channel decode; stays all-zero when the address points past the last channel.
  always_comb begin
    w_sel      = '0;
    w_doutNext = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (r_addr == ADDR_WIDTH'(i)) begin
        w_sel[i] = 1'b1;
        if (w_armed) begin
          w_doutNext = write_reg[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign w_rdHot = w_dataOk ? w_sel : '0;
  assign w_wrHot = w_rdHot & WRITABLE_MASK;
  assign w_err   = data_flag && (!w_dataOk || (w_wrHot == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_inc   <= 1'b0;
      r_dout  <= '0;
      r_rdStb <= '0;
      r_err   <= 1'b0;
    end else begin
      r_dout  <= w_doutNext;
      r_rdStb <= w_rdHot;
      r_err   <= w_err;
      if (cmd_flag) begin
        r_addr  <= dcmd[ADDR_WIDTH-1:0];
        r_inc   <= dcmd[ADDR_WIDTH];
        r_state <= ST_ARMED;
      end else if (data_flag && w_armed && r_inc) begin
        r_addr <= (r_addr >= LP_LAST) ? '0 : r_addr + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef SPI_REG_SHADOW_EN
  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] r_shadow;
  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] w_shadowNext;
  logic [CHANNEL_NUMBER-1:0]           r_pending;

  always_comb begin
    w_shadowNext = r_shadow;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (w_wrHot[i]) begin
        w_shadowNext[i*DATA_WIDTH +: DATA_WIDTH] = din;
      end
    end
  end

  // A word arriving with commit is folded into the same copy and the same strobe set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= RESET_VALUE;
      r_readReg <= RESET_VALUE;
      r_pending <= '0;
      r_wrStb   <= '0;
    end else begin
      r_shadow <= w_shadowNext;
      if (commit) begin
        r_readReg <= w_shadowNext;
        r_wrStb   <= r_pending | w_wrHot;
        r_pending <= '0;
      end else begin
        r_wrStb   <= '0;
        r_pending <= r_pending | w_wrHot;
      end
    end
  end
`else
  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] w_regNext;

  always_comb begin
    w_regNext = r_readReg;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (w_wrHot[i]) begin
        w_regNext[i*DATA_WIDTH +: DATA_WIDTH] = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_readReg <= RESET_VALUE;
      r_wrStb   <= '0;
    end else begin
      r_readReg <= w_regNext;
      r_wrStb   <= w_wrHot;
    end
  end
`endif

  assign dout     = r_dout;
  assign read_reg = r_readReg;
  assign wr_stb   = r_wrStb;
  assign rd_stb   = r_rdStb;
  assign err      = r_err;

endmodule
